fsm_pattern_gen: RTL and testbench

//  Serial stimulus source for the w-input sequence-detector FSM: shifts a loaded bit

---
 rtl/fsm_pattern_gen.sv | 165 ++++++++++++++++
 tb/tb_fsm_pattern_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_gen.sv
`default_nettype none
// ============================================================================
// fsm_pattern_gen : serial pattern source for the w-input sequence detector,
//                   with a registered four-equal-bits reference output.
// Rev 1.0
// ============================================================================
module fsm_pattern_gen #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int DIV_W = 24,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             repeat_en,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx,
  output logic [2:0]       run_len,
  output logic             expect_z
);

  localparam logic [DIV_W-1:0] C_DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [LEN_W-1:0] C_PAT_LEN    = LEN_W'(PAT_W);
  localparam logic [2:0]       C_RUN_MAX    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_last_idx;
  logic [DIV_W-1:0] r_div;
  logic [LEN_W-1:0] r_bit_idx;
  logic [2:0]       r_run_len;
  logic             r_w;
  logic             r_w_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_expect_z;

  logic [LEN_W-1:0] w_eff_len;
  logic [PAT_W-1:0] w_pat_shifted;
  logic             w_tick_bit;
  logic             w_same;
  logic [2:0]       w_next_run;
  logic             w_last;

  // A zero or oversized length selects the full pattern width.
  always_comb begin
    w_eff_len = len;
    if ((len == '0) || (len > C_PAT_LEN)) begin
      w_eff_len = C_PAT_LEN;
    end
  end

  always_comb begin
    w_pat_shifted = r_pat >> r_bit_idx;
    w_tick_bit    = w_pat_shifted[0];
    w_same        = (w_tick_bit == r_w) && (r_run_len != 3'd0);
    w_last        = (r_bit_idx == r_last_idx);
    w_next_run    = 3'd1;
    if (w_same) begin
      w_next_run = (r_run_len == C_RUN_MAX) ? C_RUN_MAX : (r_run_len + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pat      <= '0;
      r_last_idx <= '0;
      r_div      <= '0;
      r_bit_idx  <= '0;
      r_run_len  <= '0;
      r_w        <= 1'b0;
      r_w_valid  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_expect_z <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_w_valid <= 1'b0;
          r_done    <= 1'b0;
          if (start) begin
            r_pat      <= pattern;
            r_last_idx <= w_eff_len - LEN_W'(1);
            r_div      <= C_DIV_RELOAD;
            r_bit_idx  <= '0;
            r_run_len  <= '0;
            r_expect_z <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit_idx  <= '0;
            r_run_len  <= '0;
            r_w        <= 1'b0;
            r_w_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_expect_z <= 1'b0;
          end else if (r_div == '0) begin
            r_w        <= w_tick_bit;
            r_w_valid  <= 1'b1;
            r_div      <= C_DIV_RELOAD;
            r_run_len  <= w_next_run;
            r_expect_z <= (w_next_run == C_RUN_MAX);
            if (w_last) begin
              // Repeating runs keep the equal-bit history across the wrap.
              if (repeat_en) begin
                r_bit_idx <= '0;
              end else begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + LEN_W'(1);
            end
          end else begin
            r_div     <= r_div - DIV_W'(1);
            r_w_valid <= 1'b0;
          end
        end

        S_DONE: begin
          r_done    <= 1'b0;
          r_w_valid <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w        = r_w;
  assign w_valid  = r_w_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign bit_idx  = r_bit_idx;
  assign run_len  = r_run_len;
  assign expect_z = r_expect_z;

endmodule
`default_nettype wire

// File: tb/tb_fsm_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_fsm_pattern_gen : directed bench, DIV=1 and DIV=3 instances side by side.
// Rev 1.0
// ============================================================================
module tb_fsm_pattern_gen;

  logic        clk = 1'b0;
  logic        reset, start, abort, repeat_en;
  logic [15:0] pattern;
  logic [4:0]  len;

  logic        w, w_valid, busy, done, expect_z;
  logic [4:0]  bit_idx;
  logic [2:0]  run_len;
  logic        w3, w_valid3, busy3, done3, expect_z3;
  logic [4:0]  bit_idx3;
  logic [2:0]  run_len3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_w_t1;
  int e_busy [7] = '{1, 1, 0, 0, 1, 1, 0};
  int e_done [7] = '{0, 0, 1, 0, 0, 0, 1};
  int e_rl   [7] = '{0, 1, 2, 2, 0, 1, 2};
  int e_wv   [7] = '{0, 1, 1, 0, 0, 1, 1};

  always #5 clk = ~clk;

  fsm_pattern_gen #(.PAT_W(16), .LEN_W(5), .DIV_W(24), .DIV(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .repeat_en(repeat_en),
    .pattern(pattern), .len(len), .w(w), .w_valid(w_valid), .busy(busy), .done(done),
    .bit_idx(bit_idx), .run_len(run_len), .expect_z(expect_z)
  );

  fsm_pattern_gen #(.PAT_W(16), .LEN_W(5), .DIV_W(24), .DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .repeat_en(repeat_en),
    .pattern(pattern), .len(len), .w(w3), .w_valid(w_valid3), .busy(busy3), .done(done3),
    .bit_idx(bit_idx3), .run_len(run_len3), .expect_z(expect_z3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    repeat_en = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    pattern = '0;
    len     = '0;
    do_reset();

    // Reset state on both instances
    check("rst w", w, 0);             check("rst w_valid", w_valid, 0);
    check("rst busy", busy, 0);       check("rst done", done, 0);
    check("rst bit_idx", bit_idx, 0); check("rst run_len", run_len, 0);
    check("rst expect_z", expect_z, 0);
    check("rst3 busy", busy3, 0);     check("rst3 w", w3, 0);

    // T1: DIV=1, 0x00F0, len 12
    pattern  = 16'h00F0;
    len      = 5'd12;
    exp_w_t1 = 12'b0000_1111_0000;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("T1 busy@start", busy, 1);
    check("T1 bit_idx@start", bit_idx, 0);
    check("T1 w_valid@start", w_valid, 0);
    check("T1 w held@start", w, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("T1 w_valid k=%0d", k), w_valid, 1);
      check($sformatf("T1 w k=%0d", k), w, exp_w_t1[k]);
      check($sformatf("T1 run_len k=%0d", k), run_len, (k % 4) + 1);
      check($sformatf("T1 expect_z k=%0d", k), expect_z, (k % 4) == 3);
      check($sformatf("T1 busy k=%0d", k), busy, k != 11);
      check($sformatf("T1 done k=%0d", k), done, k == 11);
      if (k == 0) check("T1 bit_idx after bit0", bit_idx, 1);
    end
    step();
    check("T1 done one cycle", done, 0);
    check("T1 busy after", busy, 0);
    check("T1 w_valid after", w_valid, 0);
    check("T1 w hold", w, 0);
    check("T1 expect_z hold", expect_z, 1);
    check("T1 run_len hold", run_len, 4);

    // T2: len=0 -> full 16 bits of 0xAAAA
    do_reset();
    pattern = 16'hAAAA;
    len     = 5'd0;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("T2 w k=%0d", k), w, k % 2);
      check($sformatf("T2 run_len k=%0d", k), run_len, 1);
      check($sformatf("T2 expect_z k=%0d", k), expect_z, 0);
      check($sformatf("T2 done k=%0d", k), done, k == 15);
      if (k < 15) check($sformatf("T2 bit_idx k=%0d", k), bit_idx, k + 1);
    end

    // T3: DIV=3 instance, 0x000F, len 4
    do_reset();
    pattern = 16'h000F;
    len     = 5'd4;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("T3 busy3@start", busy3, 1);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("T3 w_valid3 c=%0d", c), w_valid3, (c % 3) == 0);
      if ((c % 3) == 0) begin
        check($sformatf("T3 w3 c=%0d", c), w3, 1);
        check($sformatf("T3 run_len3 c=%0d", c), run_len3, c / 3);
        check($sformatf("T3 expect_z3 c=%0d", c), expect_z3, c == 12);
      end
      check($sformatf("T3 done3 c=%0d", c), done3, c == 12);
      check($sformatf("T3 busy3 c=%0d", c), busy3, c < 12);
    end

    // T4: repeat 0x0003 len 2, then abort
    do_reset();
    repeat_en = 1'b1;
    pattern   = 16'h0003;
    len       = 5'd2;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("T4 w k=%0d", k), w, 1);
      check($sformatf("T4 w_valid k=%0d", k), w_valid, 1);
      check($sformatf("T4 run_len k=%0d", k), run_len, (k < 3) ? k + 1 : 4);
      check($sformatf("T4 expect_z k=%0d", k), expect_z, k >= 3);
      check($sformatf("T4 bit_idx k=%0d", k), bit_idx, (k + 1) % 2);
      check($sformatf("T4 busy k=%0d", k), busy, 1);
      check($sformatf("T4 done k=%0d", k), done, 0);
    end
    abort = 1'b1;
    step();
    abort     = 1'b0;
    repeat_en = 1'b0;
    check("T4 abort busy", busy, 0);
    check("T4 abort w", w, 0);
    check("T4 abort w_valid", w_valid, 0);
    check("T4 abort run_len", run_len, 0);
    check("T4 abort expect_z", expect_z, 0);
    check("T4 abort done", done, 0);
    step();
    check("T4 no done later", done, 0);
    check("T4 stays idle", busy, 0);

    // T5: start pulse mid-run ignored, then reset mid-run
    do_reset();
    pattern = 16'h00F0;
    len     = 5'd12;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      start = (k == 2);
      check($sformatf("T5 w k=%0d", k), w, exp_w_t1[k]);
      check($sformatf("T5 run_len k=%0d", k), run_len, (k % 4) + 1);
      check($sformatf("T5 bit_idx k=%0d", k), bit_idx, k + 1);
      check($sformatf("T5 busy k=%0d", k), busy, 1);
    end
    start = 1'b0;
    reset = 1'b0;
    step();
    check("T5 rst w", w, 0);             check("T5 rst w_valid", w_valid, 0);
    check("T5 rst busy", busy, 0);       check("T5 rst done", done, 0);
    check("T5 rst bit_idx", bit_idx, 0); check("T5 rst run_len", run_len, 0);
    check("T5 rst expect_z", expect_z, 0);
    check("T5 rst3 busy", busy3, 0);
    reset = 1'b1;

    // T6: start held high, 0x0003 len 2 -> back-to-back runs
    do_reset();
    pattern = 16'h0003;
    len     = 5'd2;
    start   = 1'b1;
    for (int j = 0; j < 7; j++) begin
      step();
      check($sformatf("T6 busy j=%0d", j), busy, e_busy[j]);
      check($sformatf("T6 done j=%0d", j), done, e_done[j]);
      check($sformatf("T6 run_len j=%0d", j), run_len, e_rl[j]);
      check($sformatf("T6 w_valid j=%0d", j), w_valid, e_wv[j]);
    end
    start = 1'b0;
    step();
    check("T6 final busy", busy, 0);
    check("T6 final done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
